up_frame_packer: RTL

- Downstream consumer of the 4-channel FIFO aggregator's read side.
- Accepts 64-bit words (`up_data` qualified by `data_valid`) in the `fifo_rdclk` domain and buffers them in a small synchronous FIFO.
- Serialises each word into a 12-byte framed byte stream (header, sequence number, payload, checksum) for the uplink byte transmitter.
- The transmitter sink uses a valid/ready handshake.

---
 rtl/up_frame_packer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/up_frame_packer.sv
// up_frame_packer: buffers 64-bit words and serialises each one into a 12-byte uplink frame.
// Define UP_FRAME_CRC8_EN to make the check byte a CRC-8 (poly 0x07) instead of a mod-256 sum.
module up_frame_packer #(
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  HDR0  = 8'h55,
    parameter logic [7:0]  HDR1  = 8'hAA
) (
    input  logic                   fifo_rdclk,
    input  logic                   rst_n,
    input  logic                   data_valid,
    input  logic [63:0]            up_data,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_byte,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StSeq, StPay, StChk} state_e;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef UP_FRAME_CRC8_EN
        logic [7:0] r;
        r = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
`else
        return acc + b;
`endif
    endfunction

    logic          in_valid_q;
    logic [63:0]   in_data_q;
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    state_e        state_q, state_d;
    logic [63:0]   sr_q;
    logic [2:0]    idx_q;
    logic [7:0]    acc_q, seq_q, drop_q;
    logic          overflow_q;
    logic          load, accept, full, push, drop;

    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign overflow   = overflow_q;

    // The word being transmitted keeps its slot until its CHK byte is accepted.
    assign full = (level_q == LW'(DEPTH));
    assign push = in_valid_q && (!full || frame_done);
    assign drop = in_valid_q && full && !frame_done;

    always_comb begin
        level_d = level_q;
        if (push && !frame_done) begin
            level_d = level_q + LW'(1);
        end else if (!push && frame_done) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        tx_valid = (state_q != StIdle);
        tx_byte  = 8'h00;
        accept   = tx_valid && tx_ready;
        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    load    = 1'b1;
                    state_d = StHdr0;
                end
            end
            StHdr0: begin
                tx_byte = HDR0;
                if (accept) state_d = StHdr1;
            end
            StHdr1: begin
                tx_byte = HDR1;
                if (accept) state_d = StSeq;
            end
            StSeq: begin
                tx_byte = seq_q;
                if (accept) state_d = StPay;
            end
            StPay: begin
                tx_byte = sr_q[63:56];
                if (accept && idx_q == 3'd7) state_d = StChk;
            end
            StChk: begin
                tx_byte = acc_q;
                if (accept) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        frame_done = accept && (state_q == StChk);
    end

    // Input stage registers the source word before it is committed to the buffer.
    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            in_data_q  <= 64'h0;
        end else begin
            in_valid_q <= data_valid;
            in_data_q  <= up_data;
        end
    end

    always_ff @(posedge fifo_rdclk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_q;
    end

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            level_q    <= level_d;
            overflow_q <= drop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (frame_done) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= 64'h0;
            idx_q   <= 3'd0;
            acc_q   <= 8'h00;
            seq_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (load) begin
                sr_q  <= mem_q[rd_ptr_q];
                idx_q <= 3'd0;
                acc_q <= 8'h00;
            end else if (accept) begin
                if (state_q == StSeq || state_q == StPay) acc_q <= chk_next(acc_q, tx_byte);
                if (state_q == StPay) begin
                    sr_q  <= {sr_q[55:0], 8'h00};
                    idx_q <= idx_q + 3'd1;
                end
            end
            if (frame_done) seq_q <= seq_q + 8'd1;
        end
    end

endmodule
